// File: rtl/glip_uart_ctrl_pkg.sv
// Shared definitions for the GLIP UART link-protocol controller.
//   ESC            escape byte that prefixes every control message
//   CREDIT_PREFIX  high nibble of the second byte of a credit message
//   CTRL_PREFIX    upper six bits of an escaped control command (0x00..0x03)
//   ingress_state_t / egress_state_t  decoder and transmitter arbiter states
package glip_uart_ctrl_pkg;

    localparam logic [7:0] ESC           = 8'hFE;
    localparam logic [3:0] CREDIT_PREFIX = 4'h8;
    localparam logic [5:0] CTRL_PREFIX   = 6'b000000;

    typedef enum logic [1:0] {
        ING_IDLE,
        ING_ESC,
        ING_CRLO
    } ingress_state_t;

    typedef enum logic [2:0] {
        EG_IDLE,
        EG_DATA,
        EG_ESC2,
        EG_CR0,
        EG_CR1,
        EG_CR2
    } egress_state_t;

endpackage

// File: rtl/glip_uart_ctrl.sv
// Byte-level link-protocol controller between the UART receiver/transmitter
// and the ingress/egress byte buffers (I/O clock domain).
//   clk, nreset                          clock, synchronous active-low reset
//   ingress_in_*                         bytes from the UART receiver (never stalled)
//   ingress_out_*                        decoded data bytes toward the ingress buffer
//   egress_in_*                          data bytes popped from the egress buffer
//   egress_out_data/enable/done          byte handshake with the UART transmitter
//   transfer_in                          one ingress credit freed by the logic side
//   ctrl_logic_rst, com_rst, error       host-requested resets and error strobe
module glip_uart_ctrl
    import glip_uart_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_CREDIT_WIDTH = 12,
    parameter int unsigned INPUT_FIFO_CREDIT = 4090,
    parameter int unsigned CREDIT_UPDATE_MIN = 512
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] ingress_in_data,
    input  logic       ingress_in_valid,
    output logic       ingress_in_ready,
    output logic [7:0] ingress_out_data,
    output logic       ingress_out_valid,
    input  logic       ingress_out_ready,
    input  logic [7:0] egress_in_data,
    input  logic       egress_in_valid,
    output logic       egress_in_ready,
    output logic [7:0] egress_out_data,
    output logic       egress_out_enable,
    input  logic       egress_out_done,
    input  logic       transfer_in,
    output logic       ctrl_logic_rst,
    output logic       com_rst,
    output logic       error
);

    localparam int unsigned CW  = FIFO_CREDIT_WIDTH;
    localparam int unsigned ECW = FIFO_CREDIT_WIDTH + 4;

    localparam logic [CW-1:0]  INIT_CREDIT = CW'(INPUT_FIFO_CREDIT);
    localparam logic [CW-1:0]  UPD_MIN     = CW'(CREDIT_UPDATE_MIN);
    localparam logic [ECW-1:0] ECREDIT_MAX = '1;

    logic irst;
    assign irst             = ~nreset | com_rst;
    assign ingress_in_ready = 1'b1;

    // ------------------------------------------------------------------
    // Ingress decoder
    // ------------------------------------------------------------------
    ingress_state_t ing_state, ing_state_nxt;
    logic [3:0]     credit_hi;
    logic           emit, proto_err, credit_hi_ld, credit_add;
    logic           ctrl_cmd, com_req, drop_err;
    logic [CW-1:0]  credit_val;

    always_comb begin
        ing_state_nxt = ing_state;
        emit          = 1'b0;
        proto_err     = 1'b0;
        credit_hi_ld  = 1'b0;
        credit_add    = 1'b0;
        ctrl_cmd      = 1'b0;
        com_req       = 1'b0;
        if (ingress_in_valid) begin
            case (ing_state)
                ING_IDLE: begin
                    if (ingress_in_data == ESC) ing_state_nxt = ING_ESC;
                    else                        emit = 1'b1;
                end
                ING_ESC: begin
                    ing_state_nxt = ING_IDLE;
                    if (ingress_in_data == ESC) begin
                        emit = 1'b1;
                    end else if (ingress_in_data[7:4] == CREDIT_PREFIX) begin
                        credit_hi_ld  = 1'b1;
                        ing_state_nxt = ING_CRLO;
                    end else if (ingress_in_data[7:2] == CTRL_PREFIX) begin
                        ctrl_cmd = 1'b1;
                        com_req  = ingress_in_data[1];
                    end else begin
                        proto_err = 1'b1;
                    end
                end
                ING_CRLO: begin
                    ing_state_nxt = ING_IDLE;
                    credit_add    = 1'b1;
                end
                default: ing_state_nxt = ING_IDLE;
            endcase
        end
    end

    // A new data byte arriving while the held one is still unaccepted is lost.
    assign drop_err   = emit & ingress_out_valid & ~ingress_out_ready;
    assign credit_val = CW'({credit_hi, ingress_in_data});

    always_ff @(posedge clk) begin
        if (irst) begin
            ing_state         <= ING_IDLE;
            ingress_out_valid <= 1'b0;
            credit_hi         <= '0;
        end else begin
            ing_state <= ing_state_nxt;
            if (credit_hi_ld) credit_hi <= ingress_in_data[3:0];
            if (emit && !drop_err) begin
                ingress_out_data  <= ingress_in_data;
                ingress_out_valid <= 1'b1;
            end else if (ingress_out_valid && ingress_out_ready) begin
                ingress_out_valid <= 1'b0;
            end
        end
    end

    // com_rst feeds irst, so a requested pulse clears itself on the next cycle.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            ctrl_logic_rst <= 1'b0;
            com_rst        <= 1'b1;
        end else begin
            com_rst <= ~irst & ctrl_cmd & com_req;
            if (!irst && ctrl_cmd) ctrl_logic_rst <= ingress_in_data[0];
        end
    end

    // ------------------------------------------------------------------
    // Egress credit (granted by host) and accumulated ingress credit
    // ------------------------------------------------------------------
    logic [ECW-1:0] ecredit;
    logic [ECW:0]   ecredit_sum;
    logic           credit_dec;
    logic [CW-1:0]  count, msg_sub;

    always_comb begin
        ecredit_sum = {1'b0, ecredit};
        if (credit_add) ecredit_sum = ecredit_sum + (ECW+1)'(credit_val);
        if (credit_dec) ecredit_sum = ecredit_sum - (ECW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (irst) begin
            ecredit <= '0;
            error   <= 1'b0;
            count   <= '0;
        end else begin
            ecredit <= ecredit_sum[ECW] ? ECREDIT_MAX : ecredit_sum[ECW-1:0];
            error   <= proto_err | drop_err | ecredit_sum[ECW];
            count   <= count + CW'(transfer_in) - msg_sub;
        end
    end

    // ------------------------------------------------------------------
    // Egress arbiter / transmitter sequencing
    // ------------------------------------------------------------------
    egress_state_t eg_state, eg_state_nxt;
    logic          grant_pending, load_msg;
    logic [CW-1:0] msg_val;
    logic [11:0]   msg_word;
    logic [7:0]    eg_byte;

    // The initial grant is not backed by accumulated transfers, so it leaves
    // the count untouched; update messages hand back exactly what was counted.
    assign msg_sub  = (load_msg && !grant_pending) ? count : '0;
    assign msg_word = 12'(msg_val);

    always_comb begin
        eg_state_nxt    = eg_state;
        load_msg        = 1'b0;
        credit_dec      = 1'b0;
        egress_in_ready = 1'b0;
        case (eg_state)
            EG_IDLE: begin
                if (!irst) begin
                    if (grant_pending || count >= UPD_MIN) begin
                        load_msg     = 1'b1;
                        eg_state_nxt = EG_CR0;
                    end else if (egress_in_valid && ecredit != '0) begin
                        egress_in_ready = 1'b1;
                        credit_dec      = 1'b1;
                        eg_state_nxt    = EG_DATA;
                    end
                end
            end
            EG_DATA: if (egress_out_done) eg_state_nxt = (eg_byte == ESC) ? EG_ESC2 : EG_IDLE;
            EG_ESC2: if (egress_out_done) eg_state_nxt = EG_IDLE;
            EG_CR0:  if (egress_out_done) eg_state_nxt = EG_CR1;
            EG_CR1:  if (egress_out_done) eg_state_nxt = EG_CR2;
            EG_CR2:  if (egress_out_done) eg_state_nxt = EG_IDLE;
            default: eg_state_nxt = EG_IDLE;
        endcase
    end

    always_comb begin
        egress_out_data = '0;
        case (eg_state)
            EG_DATA, EG_ESC2: egress_out_data = eg_byte;
            EG_CR0:           egress_out_data = ESC;
            EG_CR1:           egress_out_data = {CREDIT_PREFIX, msg_word[11:8]};
            EG_CR2:           egress_out_data = msg_word[7:0];
            default:          egress_out_data = '0;
        endcase
    end

    assign egress_out_enable = (eg_state != EG_IDLE);

    always_ff @(posedge clk) begin
        if (irst) begin
            eg_state      <= EG_IDLE;
            grant_pending <= 1'b1;
        end else begin
            eg_state <= eg_state_nxt;
            if (load_msg) grant_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_msg)   msg_val <= grant_pending ? INIT_CREDIT : count;
        if (credit_dec) eg_byte <= egress_in_data;
    end

endmodule

// File: tb/tb_glip_uart_ctrl.sv
// Self-checking bench for glip_uart_ctrl: scoreboard queues for the
// transmitter and ingress-buffer sides, a small egress-buffer model and a
// transmitter model that answers each byte with a one-cycle done strobe.
module tb_glip_uart_ctrl;

    logic       clk = 1'b0;
    logic       nreset;
    logic [7:0] ingress_in_data;
    logic       ingress_in_valid;
    logic       ingress_in_ready;
    logic [7:0] ingress_out_data;
    logic       ingress_out_valid;
    logic       ingress_out_ready;
    logic [7:0] egress_in_data;
    logic       egress_in_valid;
    logic       egress_in_ready;
    logic [7:0] egress_out_data;
    logic       egress_out_enable;
    logic       egress_out_done;
    logic       transfer_in;
    logic       ctrl_logic_rst;
    logic       com_rst;
    logic       error;

    always #5 clk = ~clk;

    glip_uart_ctrl #(
        .FIFO_CREDIT_WIDTH(12),
        .INPUT_FIFO_CREDIT(4090),
        .CREDIT_UPDATE_MIN(512)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .ingress_in_data(ingress_in_data),
        .ingress_in_valid(ingress_in_valid),
        .ingress_in_ready(ingress_in_ready),
        .ingress_out_data(ingress_out_data),
        .ingress_out_valid(ingress_out_valid),
        .ingress_out_ready(ingress_out_ready),
        .egress_in_data(egress_in_data),
        .egress_in_valid(egress_in_valid),
        .egress_in_ready(egress_in_ready),
        .egress_out_data(egress_out_data),
        .egress_out_enable(egress_out_enable),
        .egress_out_done(egress_out_done),
        .transfer_in(transfer_in),
        .ctrl_logic_rst(ctrl_logic_rst),
        .com_rst(com_rst),
        .error(error)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    // egress buffer model
    logic [7:0] eg_mem[0:15];
    int         eg_cnt = 0;
    int         eg_idx = 0;
    logic       pop_pend = 1'b0;
    assign egress_in_valid = (eg_idx < eg_cnt);
    assign egress_in_data  = eg_mem[eg_idx[3:0]];

    int err_cnt = 0;
    int com_cnt = 0;
    int pop_cnt = 0;
    int tx_wait = 0;
    logic tx_done = 1'b0;
    assign egress_out_done = tx_done;

    always @(negedge clk) begin
        if (pop_pend) eg_idx++;
        pop_pend = egress_in_ready && egress_in_valid;
        if (pop_pend) pop_cnt++;
        if (error)   err_cnt++;
        if (com_rst) com_cnt++;
        if (ingress_out_valid && ingress_out_ready) begin
            if (exp_rx.size() == 0) check("rx_unexpected", int'(ingress_out_data), 'h100);
            else                    check("rx_data", int'(ingress_out_data), int'(exp_rx.pop_front()));
        end
        if (tx_done) begin
            tx_done = 1'b0;
        end else if (egress_out_enable) begin
            if (tx_wait == 1) begin
                if (exp_tx.size() == 0) check("tx_unexpected", int'(egress_out_data), 'h100);
                else                    check("tx_data", int'(egress_out_data), int'(exp_tx.pop_front()));
                tx_done = 1'b1;
                tx_wait = 0;
            end else begin
                tx_wait++;
            end
        end else begin
            tx_wait = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        ingress_in_data  = b;
        ingress_in_valid = 1'b1;
        tick();
        ingress_in_valid = 1'b0;
        tick();
    endtask

    task automatic push_tx3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_tx.push_back(a);
        exp_tx.push_back(b);
        exp_tx.push_back(c);
    endtask

    task automatic add_eg(input logic [7:0] b);
        eg_mem[eg_cnt[3:0]] = b;
        eg_cnt++;
    endtask

    task automatic drain_tx(input string tag);
        for (int i = 0; i < 400 && (exp_tx.size() != 0 || egress_out_enable); i++) tick();
        check(tag, exp_tx.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e0, c0, p0;
        nreset            = 1'b0;
        ingress_in_data   = '0;
        ingress_in_valid  = 1'b0;
        ingress_out_ready = 1'b1;
        transfer_in       = 1'b0;
        repeat (3) tick();

        check("rst_com_rst", int'(com_rst), 1);
        check("rst_enable", int'(egress_out_enable), 0);
        check("rst_out_valid", int'(ingress_out_valid), 0);
        check("rst_error", int'(error), 0);
        check("rst_in_ready", int'(ingress_in_ready), 1);
        check("rst_ctrl", int'(ctrl_logic_rst), 0);
        check("rst_eg_ready", int'(egress_in_ready), 0);

        // initial grant of 4090 = 0xFFA
        push_tx3(8'hFE, 8'h8F, 8'hFA);
        nreset = 1'b1;
        drain_tx("grant_init");
        tick();
        check("grant_enable_low", int'(egress_out_enable), 0);

        // plain and escaped data
        e0 = err_cnt;
        exp_rx.push_back(8'h41);
        exp_rx.push_back(8'hFE);
        exp_rx.push_back(8'h42);
        send_rx(8'h41);
        send_rx(8'hFE);
        send_rx(8'hFE);
        send_rx(8'h42);
        repeat (3) tick();
        check("rx_drain", exp_rx.size(), 0);
        check("rx_no_error", err_cnt - e0, 0);

        // logic reset and communication reset commands
        send_rx(8'hFE); send_rx(8'h01);
        check("ctrl_set", int'(ctrl_logic_rst), 1);
        send_rx(8'hFE); send_rx(8'h00);
        check("ctrl_clear", int'(ctrl_logic_rst), 0);
        c0 = com_cnt;
        push_tx3(8'hFE, 8'h8F, 8'hFA);
        send_rx(8'hFE); send_rx(8'h02);
        drain_tx("grant_after_com");
        check("com_pulse", com_cnt - c0, 1);
        send_rx(8'hFE); send_rx(8'h01);
        push_tx3(8'hFE, 8'h8F, 8'hFA);
        send_rx(8'hFE); send_rx(8'h03);
        drain_tx("grant_after_com2");
        check("com_pulse2", com_cnt - c0, 2);
        check("ctrl_survives_com", int'(ctrl_logic_rst), 1);

        // egress data with credit 5, escape doubling
        p0 = pop_cnt;
        add_eg(8'h11); add_eg(8'hFE); add_eg(8'h22);
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'h22);
        send_rx(8'hFE); send_rx(8'h80); send_rx(8'h05);
        drain_tx("eg_data");
        check("eg_pops", pop_cnt - p0, 3);
        // two credits left: only two of three more bytes may go
        add_eg(8'h33); add_eg(8'h44); add_eg(8'h55);
        exp_tx.push_back(8'h33);
        exp_tx.push_back(8'h44);
        drain_tx("eg_credit_rest");
        repeat (10) tick();
        check("eg_pops_limited", pop_cnt - p0, 5);
        check("eg_left", eg_cnt - eg_idx, 1);

        // ingress buffer stall: held byte kept, next byte dropped with error
        ingress_out_ready = 1'b0;
        e0 = err_cnt;
        send_rx(8'h61);
        send_rx(8'h62);
        tick();
        check("hold_valid", int'(ingress_out_valid), 1);
        check("hold_data", int'(ingress_out_data), 'h61);
        check("drop_error", err_cnt - e0, 1);
        exp_rx.push_back(8'h61);
        ingress_out_ready = 1'b1;
        repeat (3) tick();
        check("hold_drain", exp_rx.size(), 0);
        e0 = err_cnt;
        send_rx(8'hFE); send_rx(8'h55);
        tick();
        check("bad_escape_error", err_cnt - e0, 1);

        // credit update after 512 transfers; egress data stays blocked
        p0 = pop_cnt;
        push_tx3(8'hFE, 8'h82, 8'h00);
        transfer_in = 1'b1;
        repeat (512) tick();
        transfer_in = 1'b0;
        drain_tx("credit_update");
        check("blocked_pops", pop_cnt - p0, 0);
        check("blocked_left", eg_cnt - eg_idx, 1);

        // credit counter overflow: 16 x 4095 fits, the 17th saturates
        exp_tx.push_back(8'h55);
        e0 = err_cnt;
        for (int i = 0; i < 16; i++) begin
            send_rx(8'hFE); send_rx(8'h8F); send_rx(8'hFF);
        end
        check("no_overflow", err_cnt - e0, 0);
        send_rx(8'hFE); send_rx(8'h8F); send_rx(8'hFF);
        tick();
        check("overflow_error", err_cnt - e0, 1);
        drain_tx("eg_last");
        check("eg_all_popped", eg_cnt - eg_idx, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
